lfsr_decoder: RTL and testbench

LFSR_DECODER -- requirements
Module: lfsr_decoder

---
 rtl/lfsr_decoder.sv | 116 +++++++++++
 tb/tb_lfsr_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decoder.sv
// Recovers the 5-bit LFSR seed from an encoded word by undoing NCLK encoder clocks.
// Optional KEY/MATCH compare is built when LFSR_DEC_MATCH_EN is defined.
module lfsr_decoder #(
    parameter int STEP_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [4:0]        ENC,
    input  logic [STEP_W-1:0] NCLK,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [4:0]        DEC,
    output logic              BUSY
`ifdef LFSR_DEC_MATCH_EN
    ,
    input  logic [4:0]        KEY,
    output logic              MATCH
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends combinationally on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        work_q, work_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;

    // Inverse of one shift: {n4,n3,n2,n1,n0} -> {n3,n2,n1,n0,n4^n1}.
    function automatic logic [4:0] inv_step(input logic [4:0] n);
        return {n[3:0], n[4] ^ n[1]};
    endfunction

    function automatic logic [4:0] inv_clock(input logic [4:0] n);
        logic [4:0] v;
        v = n;
        for (int i = 0; i < 5; i++) begin
            v = inv_step(v);
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    work_d  = ENC;
                    cnt_d   = NCLK;
                    state_d = (NCLK == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                work_d = inv_clock(work_q);
                cnt_d  = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            work_q  <= 5'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q == RUN);
    assign DEC       = work_q;

`ifdef LFSR_DEC_MATCH_EN
    logic match_q, match_d;

    // Compare against the value being loaded on the edge that enters DONE.
    always_comb begin
        match_d = 1'b0;
        if (state_d == DONE) begin
            match_d = (state_q == DONE) ? match_q : (work_d == KEY);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign MATCH = match_q;
`endif

endmodule

// File: tb/tb_lfsr_decoder.sv
// Directed bench for lfsr_decoder: vector table, hold/backpressure, reset abort
// and forward-model round trips. Build with LFSR_DEC_MATCH_EN to cover MATCH.
module tb_lfsr_decoder;

    localparam int STEP_W = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              IN_VALID;
    logic              IN_READY;
    logic [4:0]        ENC;
    logic [STEP_W-1:0] NCLK;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [4:0]        DEC;
    logic              BUSY;
`ifdef LFSR_DEC_MATCH_EN
    logic [4:0]        KEY;
    logic              MATCH;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_decoder #(.STEP_W(STEP_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ENC       (ENC),
        .NCLK      (NCLK),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DEC       (DEC),
        .BUSY      (BUSY)
`ifdef LFSR_DEC_MATCH_EN
        ,
        .KEY       (KEY),
        .MATCH     (MATCH)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]        enc;
        logic [STEP_W-1:0] nclk;
        logic [4:0]        key;
        logic [4:0]        exp_dec;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Forward encoder clock: five shifts of {o0^o2, o4..o1}.
    function automatic logic [4:0] fwd_clock(input logic [4:0] o);
        logic [4:0] v;
        v = o;
        for (int i = 0; i < 5; i++) begin
            v = {v[0] ^ v[2], v[4:1]};
        end
        return v;
    endfunction

    task automatic set_key(input logic [4:0] k);
`ifdef LFSR_DEC_MATCH_EN
        KEY = k;
`endif
    endtask

    task automatic chk_match(input string name, input logic exp);
`ifdef LFSR_DEC_MATCH_EN
        chk(name, 32'(MATCH), 32'(exp));
`endif
    endtask

    // Issue one request and wait for DONE; leaves the result un-released.
    task automatic start_and_wait(input string name, input logic [4:0] enc,
                                  input logic [STEP_W-1:0] nclk, input logic [4:0] key,
                                  input logic [4:0] exp_dec);
        int edges;
        int busy_cnt;
        @(negedge CLK);
        chk({name, "_in_ready"}, 32'(IN_READY), 32'd1);
        IN_VALID = 1'b1;
        ENC      = enc;
        NCLK     = nclk;
        set_key(key);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        ENC      = $urandom_range(0, 31);
        edges    = 0;
        busy_cnt = 0;
        while (!OUT_VALID && edges < 400) begin
            if (BUSY) busy_cnt++;
            chk_match({name, "_match_run"}, 1'b0);
            @(posedge CLK);
            @(negedge CLK);
            edges++;
        end
        chk({name, "_latency"}, 32'(edges), 32'(nclk));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(nclk));
        chk({name, "_dec"}, 32'(DEC), 32'(exp_dec));
        chk_match({name, "_match"}, exp_dec == key);
    endtask

    task automatic release_out(input string name);
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk({name, "_idle_ready"}, 32'(IN_READY), 32'd1);
        chk({name, "_idle_valid"}, 32'(OUT_VALID), 32'd0);
        chk_match({name, "_idle_match"}, 1'b0);
    endtask

    initial begin
        // Hand-decoded vectors: each step is 5 inverse shifts {n3,n2,n1,n0,n4^n1}.
        vecs[0] = '{enc: 5'h09, nclk: 8'd1,   key: 5'h01, exp_dec: 5'h01};
        vecs[1] = '{enc: 5'h13, nclk: 8'd2,   key: 5'h01, exp_dec: 5'h01};
        vecs[2] = '{enc: 5'h0A, nclk: 8'd0,   key: 5'h01, exp_dec: 5'h0A};
        vecs[3] = '{enc: 5'h12, nclk: 8'd1,   key: 5'h02, exp_dec: 5'h02};
        vecs[4] = '{enc: 5'h13, nclk: 8'd3,   key: 5'h0B, exp_dec: 5'h0B};
        vecs[5] = '{enc: 5'h01, nclk: 8'd1,   key: 5'h0C, exp_dec: 5'h0B};
        vecs[6] = '{enc: 5'h00, nclk: 8'd255, key: 5'h00, exp_dec: 5'h00};
        vecs[7] = '{enc: 5'h00, nclk: 8'd7,   key: 5'h1F, exp_dec: 5'h00};

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        ENC       = 5'h00;
        NCLK      = '0;
        set_key(5'h00);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_dec", 32'(DEC), 32'h00);
        chk_match("rst_match", 1'b0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            start_and_wait($sformatf("vec%0d", i), vecs[i].enc, vecs[i].nclk,
                           vecs[i].key, vecs[i].exp_dec);
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure in DONE with a competing request on IN_VALID.
        start_and_wait("hold", 5'h09, 8'd1, 5'h01, 5'h01);
        IN_VALID = 1'b1;
        ENC      = 5'h1E;
        NCLK     = 8'd3;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("hold_dec", 32'(DEC), 32'h01);
            chk("hold_in_ready", 32'(IN_READY), 32'd0);
            chk("hold_out_valid", 32'(OUT_VALID), 32'd1);
            chk_match("hold_match", 1'b1);
        end
        IN_VALID = 1'b0;
        release_out("hold");

        // Reset on the second RUN cycle aborts the request.
        @(negedge CLK);
        IN_VALID = 1'b1;
        ENC      = 5'h13;
        NCLK     = 8'd5;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("abort_busy1", 32'(BUSY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_busy2", 32'(BUSY), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_in_ready", 32'(IN_READY), 32'd1);
        chk("abort_out_valid", 32'(OUT_VALID), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_dec", 32'(DEC), 32'h00);
        chk_match("abort_match", 1'b0);
        start_and_wait("after_abort", 5'h09, 8'd1, 5'h01, 5'h01);
        release_out("after_abort");

        // Round trips through an independent forward encoder model.
        for (int r = 0; r < 4; r++) begin
            logic [4:0] seed;
            logic [4:0] enc;
            int         n;
            seed = 5'($urandom_range(1, 31));
            n    = $urandom_range(0, 6);
            enc  = seed;
            for (int k = 0; k < n; k++) enc = fwd_clock(enc);
            start_and_wait($sformatf("trip%0d", r), enc, STEP_W'(n), seed, seed);
            release_out($sformatf("trip%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
